rs485_dir_ctrl: RTL and testbench
=================================

# rs485_dir_ctrl

Parametrised multi-channel RS-485 half-duplex direction controller. Each channel owns one transceiver's receiver-disable (`f_re`) and driver-enable (`f_de`) lines. It sequences them through a driver-settle guard, a transmit window, and a post-transmit hold, with a watchdog that bounds the transmit window. It sits between the command/response framing logic and the transceiver pins, and replaces the single-channel, event-only direction register.

## Interface

Parameters:
- `CHANNELS`, default 2: number of independent transceiver channels.
- `GUARD_CYCLES`, default 4: clocks from driver enable to `tx_ready`. Legal range 0..255.
- `HOLD_CYCLES`, default 8: clocks the driver stays enabled after `tx_done`. Legal range 0..255.
- `TIMEOUT_CYCLES`, default 96000: watchdog limit in clocks, measured from leaving IDLE. 0 disables the watchdog. When nonzero it must exceed `GUARD_CYCLES`.

Ports (reset rst, asynchronous, active-high; clock clk_96M):
- `clk_96M`, input, 1: system clock.
- `rst`, input, 1: asynchronous active-high reset.
- `tx_req`, input, CHANNELS: per-channel 1-cycle pulse requesting the bus for a response.
- `tx_done`, input, CHANNELS: per-channel 1-cycle pulse marking the end of the last transmitted stop bit.
- `abort`, input, CHANNELS: per-channel level or pulse forcing an immediate return to receive.
- `f_re`, output reg, CHANNELS: 1 disables the receiver.
- `f_de`, output reg, CHANNELS: 1 enables the driver.
- `tx_ready`, output reg, CHANNELS: 1 means the UART may shift data.
- `busy`, output reg, CHANNELS: 1 whenever the channel is not IDLE.
- `timeout`, output reg, CHANNELS: 1-cycle pulse when the watchdog fires.

## Operation

- Channels are fully independent. A generate loop instantiates identical logic per bit index.
- Per-channel FSM states: IDLE, GUARD, TX, HOLD. All outputs are registered.
- `f_re` and `f_de` are always equal. Both are 1 in GUARD, TX and HOLD, and 0 in IDLE.
- `tx_ready` is 1 only in TX. `busy` is 1 in every state except IDLE.

Transitions, evaluated per clock edge in priority order:
1. `abort` in any state: go to IDLE. No `timeout` pulse.
2. Watchdog expiry in GUARD or TX: go to IDLE and pulse `timeout`.
3. IDLE with `tx_req`: go to GUARD, or directly to TX if `GUARD_CYCLES` = 0. `tx_done` is ignored in IDLE.
4. GUARD: after `GUARD_CYCLES` clocks, go to TX. `tx_req` and `tx_done` are ignored.
5. TX with `tx_done`: go to HOLD, or directly to IDLE if `HOLD_CYCLES` = 0. `tx_req` is ignored in TX, so when both arrive in the same cycle `tx_done` wins.
6. HOLD with `tx_req`: go straight to TX. The driver stays enabled and no new guard is applied.
7. HOLD after `HOLD_CYCLES` clocks: go to IDLE.

Counters:
- The phase counter is 8 bits. It is loaded on entry to GUARD/HOLD and decremented each clock.
- The watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits. It is cleared on leaving IDLE, increments in GUARD and TX, and freezes in HOLD (the watchdog does not run in HOLD).
- Neither counter wraps. Both saturate at their terminal value until reloaded.
- Reset mid-operation: all state returns to IDLE immediately and asynchronously, and the counters clear.

Reset values: `f_re`, `f_de`, `tx_ready`, `busy` and `timeout` are all 0.

## Timing

Let N be the edge that samples `tx_req` high in IDLE.
- `f_re`, `f_de` and `busy` are 1 after edge N.
- `tx_ready` is 1 after edge N+`GUARD_CYCLES`. With `GUARD_CYCLES` = 0, that is edge N itself.

Let M be the edge that samples `tx_done` high in TX.
- `tx_ready` is 0 after edge M.
- `f_re`, `f_de` and `busy` are 0 after edge M+`HOLD_CYCLES`.

Watchdog (nonzero `TIMEOUT_CYCLES`):
- If no `tx_done` arrives by edge N+`TIMEOUT_CYCLES`, then after that edge all outputs are 0 except `timeout`.
- `timeout` is 1 for exactly that one cycle.

`abort` sampled at edge A: all outputs except `timeout` are 0 after edge A.

Throughput:
- A `tx_req` in HOLD gives `tx_ready` 1 cycle later.
- A `tx_req` arriving one cycle after returning to IDLE is accepted normally.

## Test plan

1. CH0, GUARD=4, HOLD=8: `tx_req` at edge 10, `tx_done` at edge 30.
   - `f_de`/`f_re` high over edges 10–38, 0 from edge 38.
   - `tx_ready` high over edges 14–30.
   - `timeout` never asserts.
2. Watchdog, TIMEOUT=100: `tx_req` at edge 10, no `tx_done`.
   - `timeout` is a 1-cycle pulse after edge 110.
   - `f_de` = 0 after edge 110.
   - A later `tx_done` is ignored.
3. Retrigger in HOLD: `tx_done` at edge 30, `tx_req` at edge 33.
   - `f_de` stays high throughout; `tx_ready` is 1 after edge 33.
   - A second `tx_done` at edge 50 releases `f_de` after edge 58.
4. Simultaneous events:
   - `tx_req`+`tx_done` in IDLE: the channel enters GUARD.
   - `tx_req`+`tx_done` in TX: the channel enters HOLD.
   - `abort`+`tx_req` in IDLE: the channel stays IDLE.
5. Channel independence, CHANNELS=2: CH0 in TX while CH1 gets `tx_req` and then `abort` at +2 cycles.
   - CH1 `f_de` = 0 after the `abort` edge; CH0 outputs are unchanged.
6. Async `rst` pulsed mid-GUARD and mid-HOLD.
   - All outputs are 0 immediately.
   - A `tx_req` after reset release reproduces scenario 1 timing exactly.

Source files
------------

// File: rtl/rs485_dir_ctrl.sv
// rs485_dir_ctrl - multi-channel RS-485 half-duplex direction controller.
//
// Each channel drives one transceiver's receiver-disable (f_re) and
// driver-enable (f_de) pins. The channel sequence is:
//   IDLE -> GUARD (driver settles) -> TX (UART may shift) -> HOLD (last stop bit drains) -> IDLE.
// A watchdog bounds the time spent in GUARD+TX.
//
// Ports (one bit per channel unless noted):
//   clk_96M  in   system clock (1 bit)
//   rst      in   asynchronous active-high reset (1 bit)
//   tx_req   in   1-cycle pulse requesting the bus
//   tx_done  in   1-cycle pulse marking the end of the last stop bit
//   abort    in   forces an immediate return to receive
//   f_re     out  1 disables the receiver
//   f_de     out  1 enables the driver
//   tx_ready out  1 while the UART may shift data
//   busy     out  1 whenever the channel is not IDLE
//   timeout  out  1-cycle pulse when the watchdog fires
`timescale 1ns/1ps

module rs485_dir_ch #(
  parameter int GUARD_CYCLES   = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic clk_96M,
  input  logic rst,
  input  logic i_tx_req,
  input  logic i_tx_done,
  input  logic i_abort,
  output logic o_dir,
  output logic o_tx_ready,
  output logic o_busy,
  output logic o_timeout
);

  typedef enum logic [1:0] {IDLE, GUARD, TX, HOLD} state_t;

  // Watchdog width; keep at least one bit when the watchdog is disabled.
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '1;
  // The phase counter is loaded with N-1 so the exit happens on the Nth edge.
  localparam logic [7:0] PH_G = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;
  localparam logic [7:0] PH_H = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  state_t         r_state;
  logic [7:0]     r_phase;
  logic [WDW-1:0] r_wd;
  logic           r_dir;
  logic           r_tx_ready;
  logic           r_busy;
  logic           r_timeout;
  logic           w_wd_run;
  logic           w_wd_exp;

  assign w_wd_run = (r_state == GUARD) || (r_state == TX);
  // Counter value k-1 is seen at the kth edge after leaving IDLE.
  assign w_wd_exp = (TIMEOUT_CYCLES != 0) && w_wd_run && (r_wd == WD_MAX);

  always_ff @(posedge clk_96M or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= 8'd0;
      r_wd       <= '0;
      r_dir      <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // Saturating counters; loads further down take precedence.
      if (r_phase != 8'd0) r_phase <= r_phase - 8'd1;
      if (w_wd_run && (r_wd != WD_MAX)) r_wd <= r_wd + 1'b1;

      if (i_abort) begin
        r_state    <= IDLE;
        r_dir      <= 1'b0;
        r_tx_ready <= 1'b0;
        r_busy     <= 1'b0;
      end else if (w_wd_exp) begin
        r_state    <= IDLE;
        r_dir      <= 1'b0;
        r_tx_ready <= 1'b0;
        r_busy     <= 1'b0;
        r_timeout  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_tx_req) begin
              r_wd   <= '0;
              r_dir  <= 1'b1;
              r_busy <= 1'b1;
              if (GUARD_CYCLES == 0) begin
                r_state    <= TX;
                r_tx_ready <= 1'b1;
              end else begin
                r_state <= GUARD;
                r_phase <= PH_G;
              end
            end
          end
          GUARD: begin
            if (r_phase == 8'd0) begin
              r_state    <= TX;
              r_tx_ready <= 1'b1;
            end
          end
          TX: begin
            // tx_req is ignored here, so tx_done wins a same-cycle collision.
            if (i_tx_done) begin
              r_tx_ready <= 1'b0;
              if (HOLD_CYCLES == 0) begin
                r_state <= IDLE;
                r_dir   <= 1'b0;
                r_busy  <= 1'b0;
              end else begin
                r_state <= HOLD;
                r_phase <= PH_H;
              end
            end
          end
          HOLD: begin
            // Driver is already settled, so a retrigger skips the guard.
            // The watchdog resumes from its frozen value.
            if (i_tx_req) begin
              r_state    <= TX;
              r_tx_ready <= 1'b1;
            end else if (r_phase == 8'd0) begin
              r_state <= IDLE;
              r_dir   <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dir      = r_dir;
  assign o_tx_ready = r_tx_ready;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;

endmodule

module rs485_dir_ctrl #(
  parameter int CHANNELS       = 2,
  parameter int GUARD_CYCLES   = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic                clk_96M,
  input  logic                rst,
  input  logic [CHANNELS-1:0] tx_req,
  input  logic [CHANNELS-1:0] tx_done,
  input  logic [CHANNELS-1:0] abort,
  output logic [CHANNELS-1:0] f_re,
  output logic [CHANNELS-1:0] f_de,
  output logic [CHANNELS-1:0] tx_ready,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] timeout
);

  logic [CHANNELS-1:0] w_dir;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rs485_dir_ch #(
      .GUARD_CYCLES  (GUARD_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk_96M   (clk_96M),
      .rst       (rst),
      .i_tx_req  (tx_req[g]),
      .i_tx_done (tx_done[g]),
      .i_abort   (abort[g]),
      .o_dir     (w_dir[g]),
      .o_tx_ready(tx_ready[g]),
      .o_busy    (busy[g]),
      .o_timeout (timeout[g])
    );
  end

  // Receiver-disable and driver-enable share one flop so they can never differ.
  assign f_re = w_dir;
  assign f_de = w_dir;

endmodule

// File: tb/tb_rs485_dir_ctrl.sv
// Bench for rs485_dir_ctrl: a 2-channel instance (guard 4, hold 8, watchdog 100)
// driven from a vector table, plus a 1-channel instance with zero guard/hold
// and a short watchdog for the zero-length boundaries.
`timescale 1ns/1ps

module tb_rs485_dir_ctrl;

  logic       clk_96M = 1'b0;
  logic       rst;
  logic [1:0] tx_req, tx_done, abort;
  logic [1:0] f_re, f_de, tx_ready, busy, timeout;
  logic       d2_req, d2_done, d2_abort;
  logic       d2_re, d2_de, d2_rdy, d2_busy, d2_to;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_96M = ~clk_96M;

  rs485_dir_ctrl #(.CHANNELS(2), .GUARD_CYCLES(4), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk_96M(clk_96M), .rst(rst), .tx_req(tx_req), .tx_done(tx_done), .abort(abort),
    .f_re(f_re), .f_de(f_de), .tx_ready(tx_ready), .busy(busy), .timeout(timeout)
  );

  rs485_dir_ctrl #(.CHANNELS(1), .GUARD_CYCLES(0), .HOLD_CYCLES(0), .TIMEOUT_CYCLES(5)) dut2 (
    .clk_96M(clk_96M), .rst(rst), .tx_req(d2_req), .tx_done(d2_done), .abort(d2_abort),
    .f_re(d2_re), .f_de(d2_de), .tx_ready(d2_rdy), .busy(d2_busy), .timeout(d2_to)
  );

  // Inputs apply on the first edge of a record only; expected outputs hold for
  // all reps edges. Expected nibble per channel is {de, ready, busy, timeout}.
  typedef struct {
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] abt;
    int         reps;
    logic [7:0] exp;   // {ch1, ch0}
    string      tag;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sbq[$];

  function automatic void add(logic [1:0] rq, logic [1:0] dn, logic [1:0] ab, int reps,
                              logic [7:0] e, string tag);
    vec_t v;
    v.req = rq; v.done = dn; v.abt = ab; v.reps = reps; v.exp = e; v.tag = tag;
    tbl.push_back(v);
  endfunction

  function automatic void add_s1(string tag);
    add(2'b01, 2'b00, 2'b00, 4,  8'h0A, tag);
    add(2'b00, 2'b00, 2'b00, 16, 8'h0E, tag);
    add(2'b00, 2'b01, 2'b00, 8,  8'h0A, tag);
    add(2'b00, 2'b00, 2'b00, 3,  8'h00, tag);
  endfunction

  task automatic chk_dut(string tag, int idx, logic [7:0] e);
    logic [7:0] act;
    logic [1:0] e_de;
    act  = {f_de[1], tx_ready[1], busy[1], timeout[1], f_de[0], tx_ready[0], busy[0], timeout[0]};
    e_de = {e[7], e[3]};
    n_tests++;
    if (act !== e || f_re !== e_de) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got {de,rdy,busy,to}=%b re=%b, want %b re=%b",
               tag, idx, $time, act, f_re, e, e_de);
    end
  endtask

  task automatic run_tbl();
    vec_t       v;
    logic [7:0] e;
    int         step = 0;
    while (tbl.size() != 0) begin
      v = tbl.pop_front();
      for (int r = 0; r < v.reps; r++) begin
        @(negedge clk_96M);
        tx_req  = (r == 0) ? v.req  : 2'b00;
        tx_done = (r == 0) ? v.done : 2'b00;
        abort   = (r == 0) ? v.abt  : 2'b00;
        sbq.push_back(v.exp);
        @(posedge clk_96M);
        #1;
        e = sbq.pop_front();
        chk_dut(v.tag, step, e);
        step++;
      end
    end
    @(negedge clk_96M);
    tx_req = 2'b00; tx_done = 2'b00; abort = 2'b00;
  endtask

  task automatic chk_all_zero(string tag);
    n_tests++;
    if ({f_re, f_de, tx_ready, busy, timeout} !== 10'd0 ||
        {d2_re, d2_de, d2_rdy, d2_busy, d2_to} !== 5'd0) begin
      n_fail++;
      $display("FAIL %s @%0t: got re=%b de=%b rdy=%b busy=%b to=%b d2=%b, want all 0",
               tag, $time, f_re, f_de, tx_ready, busy, timeout,
               {d2_re, d2_de, d2_rdy, d2_busy, d2_to});
    end
  endtask

  // One edge on the zero-guard/zero-hold instance; e = {de, ready, busy, timeout}.
  task automatic step2(logic rq, logic dn, logic ab, logic [3:0] e, string tag);
    @(negedge clk_96M);
    d2_req = rq; d2_done = dn; d2_abort = ab;
    @(posedge clk_96M);
    #1;
    n_tests++;
    if ({d2_de, d2_rdy, d2_busy, d2_to} !== e || d2_re !== e[3]) begin
      n_fail++;
      $display("FAIL %s @%0t: got {de,rdy,busy,to}=%b re=%b, want %b",
               tag, $time, {d2_de, d2_rdy, d2_busy, d2_to}, d2_re, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 ns");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    tx_req = '0; tx_done = '0; abort = '0;
    d2_req = 1'b0; d2_done = 1'b0; d2_abort = 1'b0;
    #3;
    chk_all_zero("reset_state");
    repeat (2) @(negedge clk_96M);
    rst = 1'b0;
    add(2'b00, 2'b00, 2'b00, 2, 8'h00, "idle");

    // Basic guard / transmit / hold window.
    add_s1("s1_basic");

    // Watchdog: no tx_done; expiry at N+100, late tx_done ignored.
    add(2'b01, 2'b00, 2'b00, 4,  8'h0A, "s2_wdog");
    add(2'b00, 2'b00, 2'b00, 96, 8'h0E, "s2_wdog");
    add(2'b00, 2'b00, 2'b00, 1,  8'h01, "s2_wdog");
    add(2'b00, 2'b01, 2'b00, 2,  8'h00, "s2_wdog");

    // Retrigger in HOLD: straight back to TX, driver never drops.
    add(2'b01, 2'b00, 2'b00, 4,  8'h0A, "s3_retrig");
    add(2'b00, 2'b00, 2'b00, 16, 8'h0E, "s3_retrig");
    add(2'b00, 2'b01, 2'b00, 3,  8'h0A, "s3_retrig");
    add(2'b01, 2'b00, 2'b00, 17, 8'h0E, "s3_retrig");
    add(2'b00, 2'b01, 2'b00, 8,  8'h0A, "s3_retrig");
    add(2'b00, 2'b00, 2'b00, 2,  8'h00, "s3_retrig");

    // Simultaneous events.
    add(2'b01, 2'b01, 2'b00, 4, 8'h0A, "s4_req_done_idle");
    add(2'b00, 2'b00, 2'b00, 1, 8'h0E, "s4_req_done_idle");
    add(2'b01, 2'b01, 2'b00, 8, 8'h0A, "s4_req_done_tx");
    add(2'b00, 2'b00, 2'b00, 1, 8'h00, "s4_req_done_tx");
    add(2'b01, 2'b00, 2'b01, 3, 8'h00, "s4_abort_req_idle");

    // Channel independence: CH1 aborted while CH0 transmits.
    add(2'b01, 2'b00, 2'b00, 4, 8'h0A, "s5_indep");
    add(2'b00, 2'b00, 2'b00, 2, 8'h0E, "s5_indep");
    add(2'b10, 2'b00, 2'b00, 2, 8'hAE, "s5_indep");
    add(2'b00, 2'b00, 2'b10, 3, 8'h0E, "s5_indep");
    add(2'b00, 2'b01, 2'b00, 8, 8'h0A, "s5_indep");
    add(2'b00, 2'b00, 2'b00, 1, 8'h00, "s5_indep");

    // Abort in GUARD and in HOLD.
    add(2'b01, 2'b00, 2'b00, 2, 8'h0A, "abort_guard");
    add(2'b00, 2'b00, 2'b01, 2, 8'h00, "abort_guard");
    add(2'b01, 2'b00, 2'b00, 4, 8'h0A, "abort_hold");
    add(2'b00, 2'b00, 2'b00, 1, 8'h0E, "abort_hold");
    add(2'b00, 2'b01, 2'b00, 2, 8'h0A, "abort_hold");
    add(2'b00, 2'b00, 2'b01, 2, 8'h00, "abort_hold");
    run_tbl();

    // Asynchronous reset mid-GUARD.
    add(2'b01, 2'b00, 2'b00, 2, 8'h0A, "s6_pre_guard");
    run_tbl();
    #2 rst = 1'b1;
    #1 chk_all_zero("s6_rst_guard");
    @(negedge clk_96M);
    rst = 1'b0;

    // Asynchronous reset mid-HOLD, then the basic timing must repeat exactly.
    add(2'b01, 2'b00, 2'b00, 4,  8'h0A, "s6_pre_hold");
    add(2'b00, 2'b00, 2'b00, 16, 8'h0E, "s6_pre_hold");
    add(2'b00, 2'b01, 2'b00, 3,  8'h0A, "s6_pre_hold");
    run_tbl();
    #2 rst = 1'b1;
    #1 chk_all_zero("s6_rst_hold");
    @(negedge clk_96M);
    rst = 1'b0;
    add_s1("s6_replay");
    run_tbl();

    // Zero guard, zero hold, watchdog of 5.
    step2(1'b1, 1'b0, 1'b0, 4'b1110, "g0_req_to_tx");
    step2(1'b0, 1'b1, 1'b0, 4'b0000, "h0_done_to_idle");
    step2(1'b1, 1'b0, 1'b0, 4'b1110, "idle_next_cycle_req");
    for (int i = 0; i < 4; i++) step2(1'b0, 1'b0, 1'b0, 4'b1110, "wd5_running");
    step2(1'b0, 1'b0, 1'b0, 4'b0001, "wd5_fire");
    step2(1'b0, 1'b0, 1'b0, 4'b0000, "wd5_pulse_end");
    step2(1'b0, 1'b1, 1'b0, 4'b0000, "idle_done_ignored");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
